// File: rtl/uart_tx_queue.sv
// uart_tx_queue: transmit buffer between the CPU memory stage and an external UART chip.
// The memory stage pushes bytes with a one-cycle strobe. They are queued in a FIFO and drained
// one at a time. For each byte the block requests the shared ram1 data bus and drives the byte.
// It then pulses uart_wrn low and waits for the UART's tbre/tsre status before the next byte.
//
// Ports:
//   cpu_clk50, cpu_rst   clock, asynchronous active-low reset
//   txq_wr, txq_data     push strobe and byte
//   txq_flush            clear queued bytes and the overflow flag
//   txq_full/empty/count FIFO status
//   txq_busy             transmit FSM not idle
//   txq_overflow         sticky: a push was dropped because the FIFO was full
//   bus_req, bus_gnt     ram1 data bus request/grant
//   uart_data, _oe       byte for ram1_data_bus[7:0] and its tri-state enable
//   uart_wrn             UART write strobe, active-low
//   uart_tbre, uart_tsre UART status inputs (asynchronous, synchronised here)
module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned WRN_LOW_CYC = 4,
    parameter int unsigned GUARD_CYC   = 4
) (
    input  logic                  cpu_clk50,
    input  logic                  cpu_rst,
    input  logic                  txq_wr,
    input  logic [7:0]            txq_data,
    input  logic                  txq_flush,
    output logic                  txq_full,
    output logic                  txq_empty,
    output logic [DEPTH_LOG2:0]   txq_count,
    output logic                  txq_busy,
    output logic                  txq_overflow,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [7:0]            uart_data,
    output logic                  uart_data_oe,
    output logic                  uart_wrn,
    input  logic                  uart_tbre,
    input  logic                  uart_tsre
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        StIdle, StReq, StSetup, StStrobe, StHold, StGuard, StWait
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cyc_q, cyc_d;
    logic                    wrn_q, wrn_d;
    logic                    oe_q, oe_d;
    logic                    req_q, req_d;
    logic [7:0]              data_q, data_d;

    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic                    overflow_q;
    logic                    push, pop, full, empty;

    logic [1:0]              tbre_sync_q, tsre_sync_q;
    logic                    tx_ready;

    assign full      = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push      = txq_wr && !txq_flush && (!full || pop);
    assign tx_ready  = tbre_sync_q[1] && tsre_sync_q[1];

    // Status synchronisers; reset to "ready" so a missing UART does not stall the queue.
    always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
        if (!cpu_rst) begin
            tbre_sync_q <= 2'b11;
            tsre_sync_q <= 2'b11;
        end else begin
            tbre_sync_q <= {tbre_sync_q[0], uart_tbre};
            tsre_sync_q <= {tsre_sync_q[0], uart_tsre};
        end
    end

    // FIFO storage, no reset needed: contents are only read below count_q.
    always_ff @(posedge cpu_clk50) begin
        if (push) begin
            mem[wr_ptr_q] <= txq_data;
        end
    end

    always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
        if (!cpu_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (txq_flush) begin
            // A byte popped this cycle is already captured in data_q and still goes out.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (txq_wr && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit FSM: outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        wrn_d   = wrn_q;
        oe_d    = oe_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                end
            end
            StReq: begin
                if (empty) begin
                    // Queue flushed while waiting for the bus.
                    state_d = StIdle;
                    req_d   = 1'b0;
                end else if (bus_gnt) begin
                    pop     = 1'b1;
                    data_d  = mem[rd_ptr_q];
                    oe_d    = 1'b1;
                    cyc_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cyc_q == 8'(SETUP_CYC - 1)) begin
                    cyc_d   = '0;
                    wrn_d   = 1'b0;
                    state_d = StStrobe;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            StStrobe: begin
                if (cyc_q == 8'(WRN_LOW_CYC - 1)) begin
                    cyc_d   = '0;
                    wrn_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            StHold: begin
                // Keeps oe from switching on the same edge as the rising uart_wrn.
                oe_d    = 1'b0;
                req_d   = 1'b0;
                cyc_d   = '0;
                state_d = StGuard;
            end
            StGuard: begin
                // Lets the UART pull tbre low before it is sampled.
                if (cyc_q == 8'(GUARD_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = StWait;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            StWait: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            wrn_q   <= 1'b1;
            oe_q    <= 1'b0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            wrn_q   <= wrn_d;
            oe_q    <= oe_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign txq_full     = full;
    assign txq_empty    = empty;
    assign txq_count    = count_q;
    assign txq_busy     = (state_q != StIdle);
    assign txq_overflow = overflow_q;
    assign bus_req      = req_q;
    assign uart_data    = data_q;
    assign uart_data_oe = oe_q;
    assign uart_wrn     = wrn_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue. Stimulus pushes the bytes it expects to see on the UART into a
// scoreboard queue. A monitor checks every uart_wrn pulse against the head of that queue,
// and also checks the pulse width and the oe/bus_req framing.
module tb_uart_tx_queue;

    logic       cpu_clk50 = 1'b0;
    logic       cpu_rst   = 1'b0;
    logic       txq_wr    = 1'b0;
    logic [7:0] txq_data  = 8'h00;
    logic       txq_flush = 1'b0;
    logic       txq_full, txq_empty, txq_busy, txq_overflow;
    logic [4:0] txq_count;
    logic       bus_req;
    logic       bus_gnt   = 1'b0;
    logic [7:0] uart_data;
    logic       uart_data_oe, uart_wrn;
    logic       uart_tbre = 1'b1;
    logic       uart_tsre = 1'b1;

    uart_tx_queue dut (
        .cpu_clk50    (cpu_clk50),
        .cpu_rst      (cpu_rst),
        .txq_wr       (txq_wr),
        .txq_data     (txq_data),
        .txq_flush    (txq_flush),
        .txq_full     (txq_full),
        .txq_empty    (txq_empty),
        .txq_count    (txq_count),
        .txq_busy     (txq_busy),
        .txq_overflow (txq_overflow),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .uart_data    (uart_data),
        .uart_data_oe (uart_data_oe),
        .uart_wrn     (uart_wrn),
        .uart_tbre    (uart_tbre),
        .uart_tsre    (uart_tsre)
    );

    always #5 cpu_clk50 = ~cpu_clk50;

    int unsigned cycle = 0;
    always @(posedge cpu_clk50) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_q[$];
    int          fall_cnt   = 0;
    int unsigned fall_cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Monitor: samples on the falling clock edge, away from the active edge.
    initial begin
        logic       prev_wrn;
        logic       prev_oe;
        logic       in_pulse;
        int         low_len;
        logic [7:0] cur_byte;
        logic [7:0] exp_byte;
        prev_wrn = 1'b1;
        prev_oe  = 1'b0;
        in_pulse = 1'b0;
        low_len  = 0;
        cur_byte = 8'h00;
        forever begin
            @(negedge cpu_clk50);
            if (!cpu_rst) begin
                // A pulse cut short by reset is expected; drop it.
                prev_wrn = 1'b1;
                prev_oe  = 1'b0;
                in_pulse = 1'b0;
            end else begin
                if (prev_wrn && !uart_wrn) begin
                    fall_cnt++;
                    fall_cycle = cycle;
                    in_pulse   = 1'b1;
                    low_len    = 1;
                    cur_byte   = uart_data;
                    check("oe before wrn fall", 32'(prev_oe), 32'd1);
                    check("oe at wrn fall", 32'(uart_data_oe), 32'd1);
                    check("bus_req at wrn fall", 32'(bus_req), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected strobe: data 0x%0h, no byte expected (cycle %0d)",
                                 uart_data, cycle);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check("strobe data", 32'(uart_data), 32'(exp_byte));
                    end
                end else if (!prev_wrn && !uart_wrn) begin
                    low_len++;
                end else if (!prev_wrn && uart_wrn && in_pulse) begin
                    in_pulse = 1'b0;
                    check("wrn low width", 32'(low_len), 32'd4);
                    check("oe at wrn rise", 32'(uart_data_oe), 32'd1);
                    check("data held through pulse", 32'(uart_data), 32'(cur_byte));
                end
                prev_wrn = uart_wrn;
                prev_oe  = uart_data_oe;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge cpu_clk50);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit expect_out);
        txq_wr   = 1'b1;
        txq_data = d;
        if (expect_out) exp_q.push_back(d);
        tick();
        txq_wr   = 1'b0;
    endtask

    task automatic do_reset();
        txq_wr    = 1'b0;
        txq_flush = 1'b0;
        bus_gnt   = 1'b0;
        uart_tbre = 1'b1;
        uart_tsre = 1'b1;
        cpu_rst   = 1'b0;
        tick(3);
        exp_q.delete();
        cpu_rst   = 1'b1;
        tick();
    endtask

    task automatic wait_falls(input int target, input int budget, input string name);
        int k = 0;
        while (fall_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(fall_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(!txq_busy && txq_empty) && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(!txq_busy && txq_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          base;

        // Reset values, sampled while reset is held.
        tick(2);
        check("reset uart_wrn", 32'(uart_wrn), 32'd1);
        check("reset oe", 32'(uart_data_oe), 32'd0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset uart_data", 32'(uart_data), 32'h00);
        check("reset overflow", 32'(txq_overflow), 32'd0);
        check("reset count", 32'(txq_count), 32'd0);
        check("reset empty", 32'(txq_empty), 32'd1);
        check("reset full", 32'(txq_full), 32'd0);
        check("reset busy", 32'(txq_busy), 32'd0);
        cpu_rst = 1'b1;
        tick();

        // Single byte with bus granted: latency to wrn fall is 3+SETUP_CYC = 5.
        bus_gnt = 1'b1;
        base    = fall_cnt;
        t0      = cycle;
        push(8'h41, 1'b1);
        wait_falls(base + 1, 20, "single byte strobe");
        check("push to wrn fall latency", fall_cycle - t0, 32'd5);
        wait_idle(40, "single byte drained");
        check("count after single byte", 32'(txq_count), 32'd0);

        // Overflow: 17 pushes without grant, last byte dropped.
        do_reset();
        base = fall_cnt;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        check("full after 16 pushes", 32'(txq_full), 32'd1);
        check("count after 16 pushes", 32'(txq_count), 32'd16);
        check("no overflow at 16", 32'(txq_overflow), 32'd0);
        check("bus_req while waiting", 32'(bus_req), 32'd1);
        push(8'h10, 1'b0);
        check("overflow after 17th push", 32'(txq_overflow), 32'd1);
        check("count stays 16", 32'(txq_count), 32'd16);
        check("no strobe without grant", 32'(fall_cnt), 32'(base));
        bus_gnt = 1'b1;
        wait_falls(base + 16, 16 * 40, "16 bytes emitted");
        wait_idle(60, "16 bytes drained");
        check("scoreboard empty after drain", 32'(exp_q.size()), 32'd0);
        check("overflow sticky after drain", 32'(txq_overflow), 32'd1);
        txq_flush = 1'b1;
        tick();
        txq_flush = 1'b0;
        check("flush clears overflow", 32'(txq_overflow), 32'd0);

        // Full FIFO with a push coincident with the pop.
        do_reset();
        base = fall_cnt;
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
        check("full before coincident push", 32'(txq_full), 32'd1);
        txq_wr   = 1'b1;
        txq_data = 8'h30;
        bus_gnt  = 1'b1;
        exp_q.push_back(8'h30);
        tick();
        txq_wr   = 1'b0;
        check("count after push+pop at full", 32'(txq_count), 32'd16);
        check("no overflow on push+pop", 32'(txq_overflow), 32'd0);
        wait_falls(base + 17, 17 * 40, "17 bytes emitted");
        wait_idle(60, "17 bytes drained");

        // UART status holds off the second byte; release to fall is 7 cycles.
        do_reset();
        bus_gnt = 1'b1;
        base    = fall_cnt;
        push(8'h55, 1'b1);
        push(8'h66, 1'b1);
        wait_falls(base + 1, 20, "first byte before tbre hold");
        uart_tbre = 1'b0;
        tick(40);
        check("held off by tbre=0", 32'(fall_cnt), 32'(base + 1));
        uart_tbre = 1'b1;
        uart_tsre = 1'b0;
        tick(20);
        check("held off by tsre=0", 32'(fall_cnt), 32'(base + 1));
        t0        = cycle;
        uart_tsre = 1'b1;
        wait_falls(base + 2, 30, "second byte after release");
        check("status release to wrn fall", fall_cycle - t0, 32'd7);
        wait_idle(40, "status test drained");

        // Reset in the middle of a strobe.
        do_reset();
        bus_gnt = 1'b1;
        base    = fall_cnt;
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        wait_falls(base + 1, 20, "strobe before reset");
        tick();
        check("wrn low before reset", 32'(uart_wrn), 32'd0);
        cpu_rst = 1'b0;
        #1;
        check("reset forces wrn high", 32'(uart_wrn), 32'd1);
        check("reset forces oe low", 32'(uart_data_oe), 32'd0);
        check("reset empties queue", 32'(txq_empty), 32'd1);
        check("reset clears bus_req", 32'(bus_req), 32'd0);
        exp_q.delete();
        tick(2);
        cpu_rst = 1'b1;
        base    = fall_cnt;
        tick(60);
        check("no strobes after reset", 32'(fall_cnt), 32'(base));

        // Flush during a strobe with 5 bytes queued; a simultaneous push loses to flush.
        do_reset();
        base = fall_cnt;
        for (int i = 0; i < 6; i++) push(8'(8'h70 + i), 1'b1);
        bus_gnt = 1'b1;
        wait_falls(base + 1, 20, "strobe before flush");
        check("5 bytes queued at flush", 32'(txq_count), 32'd5);
        txq_flush = 1'b1;
        txq_wr    = 1'b1;
        txq_data  = 8'h99;
        tick();
        txq_flush = 1'b0;
        txq_wr    = 1'b0;
        exp_q.delete();
        check("count after flush", 32'(txq_count), 32'd0);
        check("empty after flush", 32'(txq_empty), 32'd1);
        wait_idle(60, "idle after flush");
        tick(30);
        check("single strobe across flush", 32'(fall_cnt), 32'(base + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
